// File: rtl/cond_flag_unit_if.sv
// rtl/cond_flag_unit_if.sv - ALU-decode to condition/flag unit control bundle
//
// Purpose: carries the decoder/ALU outputs into cond_flag_unit and the gated
// write enables, condition result, stored flags and optional counters back.
// Signal summary:
//   instr_valid  live instruction (0 = bubble/stall)
//   cond[3:0]    condition field Instr[31:28]
//   alu_flags    ALU {N,Z,C,V} for the current instruction
//   Flagw[1:0]   [1] writes N,Z ; [0] writes C,V
//   NoWrite      suppress register write-back
//   PCS/RegW/MemW   ungated write requests
//   PCSrc/RegWrite/MemWrite  gated write enables
//   CondEx       condition passed
//   flags_q      stored {N,Z,C,V}
//   exec_cnt/squash_cnt  executed / squashed instruction counts
// master = decoder/ALU side, slave = cond_flag_unit.
interface cond_flag_unit_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic [3:0]       cond;
  logic [3:0]       alu_flags;
  logic [1:0]       Flagw;
  logic             NoWrite;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       flags_q;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output instr_valid, cond, alu_flags, Flagw, NoWrite, PCS, RegW, MemW,
    input  PCSrc, RegWrite, MemWrite, CondEx, flags_q, exec_cnt, squash_cnt
  );

  modport slave (
    input  instr_valid, cond, alu_flags, Flagw, NoWrite, PCS, RegW, MemW,
    output PCSrc, RegWrite, MemWrite, CondEx, flags_q, exec_cnt, squash_cnt
  );
endinterface

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - NZCV flag register, condition evaluation and write gating
//
// Purpose: holds the architectural NZCV flags, evaluates the instruction
// condition field against them and gates PC/register/memory writes.
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  synchronous active-low reset
//   bus    cond_flag_unit_if.slave (see interface file for signal list)
// Optional feature: define COND_COUNT_EN to build the executed/squashed
// instruction counters (CNT_W bits, wrapping); otherwise they read 0.
module cond_flag_unit #(
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  cond_flag_unit_if.slave  bus
);

  logic [3:0] r_flags;
  logic       w_n;
  logic       w_z;
  logic       w_c;
  logic       w_v;
  logic       w_cond_ex;
  logic       w_live;

  assign w_n = r_flags[3];
  assign w_z = r_flags[2];
  assign w_c = r_flags[1];
  assign w_v = r_flags[0];

  // Condition uses only the registered flags, never same-cycle alu_flags,
  // so flags written in cycle k first steer instructions in cycle k+1.
  always_comb begin
    w_cond_ex = 1'b0;
    case (bus.cond)
      4'd0:    w_cond_ex = w_z;
      4'd1:    w_cond_ex = ~w_z;
      4'd2:    w_cond_ex = w_c;
      4'd3:    w_cond_ex = ~w_c;
      4'd4:    w_cond_ex = w_n;
      4'd5:    w_cond_ex = ~w_n;
      4'd6:    w_cond_ex = w_v;
      4'd7:    w_cond_ex = ~w_v;
      4'd8:    w_cond_ex = w_c & ~w_z;
      4'd9:    w_cond_ex = ~w_c | w_z;
      4'd10:   w_cond_ex = (w_n == w_v);
      4'd11:   w_cond_ex = (w_n != w_v);
      4'd12:   w_cond_ex = ~w_z & (w_n == w_v);
      4'd13:   w_cond_ex = w_z | (w_n != w_v);
      4'd14:   w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;
    endcase
  end

  // instr_valid first: a bubble forces live low even if cond is unknown.
  assign w_live = bus.instr_valid & w_cond_ex;

  assign bus.CondEx   = w_cond_ex;
  assign bus.PCSrc    = rst_n & bus.PCS & w_live;
  assign bus.RegWrite = rst_n & bus.RegW & ~bus.NoWrite & w_live;
  assign bus.MemWrite = rst_n & bus.MemW & w_live;
  assign bus.flags_q  = r_flags;

  // N,Z and C,V are separate write groups; an unwritten group holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (w_live) begin
      if (bus.Flagw[1]) r_flags[3:2] <= bus.alu_flags[3:2];
      if (bus.Flagw[0]) r_flags[1:0] <= bus.alu_flags[1:0];
    end
  end

`ifdef COND_COUNT_EN
  logic [CNT_W-1:0] r_exec_cnt;
  logic [CNT_W-1:0] r_squash_cnt;

  // Free-running wrap counters: every live slot is either executed or squashed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exec_cnt   <= '0;
      r_squash_cnt <= '0;
    end else if (bus.instr_valid) begin
      if (w_cond_ex) r_exec_cnt   <= r_exec_cnt + CNT_W'(1);
      else           r_squash_cnt <= r_squash_cnt + CNT_W'(1);
    end
  end

  assign bus.exec_cnt   = r_exec_cnt;
  assign bus.squash_cnt = r_squash_cnt;
`else
  assign bus.exec_cnt   = '0;
  assign bus.squash_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - self-checking bench for cond_flag_unit
module tb_cond_flag_unit;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [3:0]       m_flags;
  logic [CNT_W-1:0] m_exec;
  logic [CNT_W-1:0] m_squash;

  cond_flag_unit_if #(.CNT_W(CNT_W)) bus ();

  cond_flag_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference condition: base predicate per pair, odd codes invert it.
  function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'd14) return 1'b1;
    if (c == 4'd15) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction

  // One clock: drive, check combinational outputs, clock, check state.
  task automatic step(input logic rn, input logic vld, input logic [3:0] c,
                      input logic [3:0] alu, input logic [1:0] fw, input logic nw,
                      input logic pcs, input logic regw, input logic memw);
    bit pass, live;
    rst_n = rn;
    bus.instr_valid = vld; bus.cond = c; bus.alu_flags = alu; bus.Flagw = fw;
    bus.NoWrite = nw; bus.PCS = pcs; bus.RegW = regw; bus.MemW = memw;
    #2;
    pass = $isunknown(c) ? 1'b0 : ref_pass(c, m_flags);
    live = vld && pass;
    if (!$isunknown(c)) check("CondEx", 32'(bus.CondEx), 32'(pass));
    check("PCSrc",    32'(bus.PCSrc),    32'(rn && pcs && live));
    check("RegWrite", 32'(bus.RegWrite), 32'(rn && regw && !nw && live));
    check("MemWrite", 32'(bus.MemWrite), 32'(rn && memw && live));
    @(posedge clk);
    if (!rn) begin
      m_flags = 4'h0; m_exec = '0; m_squash = '0;
    end else if (vld) begin
      if (live) begin
        if (fw[1]) m_flags[3:2] = alu[3:2];
        if (fw[0]) m_flags[1:0] = alu[1:0];
      end
`ifdef COND_COUNT_EN
      if (pass) m_exec = m_exec + 1'b1;
      else      m_squash = m_squash + 1'b1;
`endif
    end
    #1;
    check("flags_q", 32'(bus.flags_q), 32'(m_flags));
    check("exec_cnt", 32'(bus.exec_cnt), 32'(m_exec));
    check("squash_cnt", 32'(bus.squash_cnt), 32'(m_squash));
  endtask

  task automatic set_flags(input logic [3:0] f);
    step(1'b1, 1'b1, 4'd14, f, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] preload [4];
    n_cmp = 0; n_err = 0;
    m_flags = 4'h0; m_exec = '0; m_squash = '0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0; bus.cond = 4'd0; bus.alu_flags = 4'h0; bus.Flagw = 2'b00;
    bus.NoWrite = 1'b0; bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
    @(posedge clk); #1;

    // Reset beats a simultaneous live flag write.
    step(1'b0, 1'b1, 4'd14, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 4'd14, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    check("reset_flags", 32'(bus.flags_q), 32'h0);
    step(1'b1, 1'b0, 4'd14, 4'hF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_reset_flags", 32'(bus.flags_q), 32'h0);

    // Group split.
    step(1'b1, 1'b1, 4'd14, 4'b1111, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    check("split_nz", 32'(bus.flags_q), 32'hC);
    step(1'b1, 1'b1, 4'd14, 4'b0011, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    check("split_cv", 32'(bus.flags_q), 32'hF);

    // Condition sweep over several stored flag values (bubbles: no update).
    preload[0] = 4'b0100; preload[1] = 4'b0010; preload[2] = 4'b1001; preload[3] = 4'b1000;
    for (int p = 0; p < 4; p++) begin
      set_flags(preload[p]);
      for (int c = 0; c < 16; c++)
        step(1'b1, 1'b0, 4'(c), 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    end

    // Gating.
    set_flags(4'h0);
    step(1'b1, 1'b1, 4'd0, 4'h0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    check("gate_eq_pc", 32'(bus.PCSrc), 32'd0);
    bus.cond = 4'd1; #1;
    check("gate_ne_pc", 32'(bus.PCSrc), 32'd1);
    check("gate_ne_reg", 32'(bus.RegWrite), 32'd1);
    step(1'b1, 1'b1, 4'd1, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1);

    // Squash and bubble leave flags alone; live write lands.
    step(1'b1, 1'b1, 4'd0, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("squash_hold", 32'(bus.flags_q), 32'h0);
    step(1'b1, 1'b0, 4'd14, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bubble_hold", 32'(bus.flags_q), 32'h0);
    step(1'b1, 1'b0, 4'bxxxx, 4'hF, 2'bxx, 1'b1, 1'b0, 1'b0, 1'b0);
    check("bubble_x_hold", 32'(bus.flags_q), 32'h0);
    step(1'b1, 1'b1, 4'd14, 4'hF, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("live_write", 32'(bus.flags_q), 32'hF);

    // Counter wrap: 17 executes, 3 squashes, then reset.
    step(1'b0, 1'b0, 4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++)
      step(1'b1, 1'b1, 4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'd0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef COND_COUNT_EN
    check("exec_wrap", 32'(bus.exec_cnt), 32'd1);
    check("squash_three", 32'(bus.squash_cnt), 32'd3);
`endif
    step(1'b0, 1'b0, 4'd14, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("cnt_reset", 32'(bus.exec_cnt), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(31) != 0), ($urandom_range(3) != 0), 4'($urandom),
           4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the ALU-decode control interface. Takes the ALU-decode outputs (Flagw, NoWrite) and the raw ALU flags, and holds the architectural NZCV flag register.
- Evaluates the instruction's 4-bit condition field against the stored flags and gates PC, register-file and memory writes accordingly.
- Sits between the control decoder / ALU and the PC / register file / data memory of the single-cycle core.

Parameters:
- CNT_W, 16, width of the optional executed/squashed instruction counters (used only with COND_COUNT_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous reset, active-low
- instr_valid  input  1  current instruction is live; 0 = bubble/stall
- cond  input  4  instruction condition field, Instr[31:28]
- alu_flags  input  4  ALU result flags {N,Z,C,V} for the current instruction
- Flagw  input  2  flag-group write request: [1] updates N,Z; [0] updates C,V
- NoWrite  input  1  suppress register write-back (compare-type instructions)
- PCS  input  1  instruction writes the PC
- RegW  input  1  instruction writes the register file
- MemW  input  1  instruction writes memory
- PCSrc  output  1  gated PC write
- RegWrite  output  1  gated register write
- MemWrite  output  1  gated memory write
- CondEx  output  1  condition-passed indicator
- flags_q  output  4  stored {N,Z,C,V}
- exec_cnt  output  CNT_W  executed-instruction count (COND_COUNT_EN only)
- squash_cnt  output  CNT_W  squashed-instruction count (COND_COUNT_EN only)

Behaviour:
- Reset: one clock; reset is synchronous and active-low. When rst_n=0 at a rising clk edge, flags_q <= 4'b0000 and both counters <= 0. Reset takes priority over every other update, including a flag write in the same cycle.
- CondEx is combinational from cond and the registered flags_q. It never uses the same-cycle alu_flags. Condition table:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z & (N==V)
  - 13 LE: Z | (N!=V)
  - 14 AL: 1
  - 15 (reserved): 0
- Output gating (combinational, zero latency), with live = instr_valid & CondEx:
  - PCSrc = PCS & live
  - RegWrite = RegW & !NoWrite & live
  - MemWrite = MemW & live
- Flag update on clk edge, when rst_n=1 and live=1:
  - Flagw[1]=1: N,Z <= alu_flags[3:2]
  - Flagw[0]=1: C,V <= alu_flags[1:0]
  - Each group updates independently. Groups not written hold their value.
- No flag update when instr_valid=0, CondEx=0, or Flagw=0.
- Flags written in cycle k are visible to CondEx in cycle k+1 (one-cycle latency).
- A failed-condition compare (NoWrite=1, Flagw=3) changes nothing.
- Outputs are driven to 0 while rst_n=0. CondEx still reflects flags_q, which is 0 during reset, so EQ/NE/etc. evaluate against zero flags.
- X on cond/Flagw while instr_valid=0 must not propagate into flags_q.

Optional Feature:
- Macro COND_COUNT_EN.
- Defined:
  - exec_cnt increments by 1 on every edge with instr_valid=1 & CondEx=1.
  - squash_cnt increments by 1 on every edge with instr_valid=1 & CondEx=0.
  - Both counters wrap modulo 2^CNT_W (all-ones -> 0) and saturate never.
  - Both counters clear on reset.
- Undefined: exec_cnt and squash_cnt are tied to 0 and no counter flops exist.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with Flagw=3, alu_flags=4'hF, instr_valid=1, cond=14 -> flags_q=0, PCSrc/RegWrite/MemWrite=0. Release -> flags_q still 0 until the next live write.
- Group split: flags_q=0; cond=14, Flagw=2'b10, alu_flags=4'b1111 -> next cycle flags_q=4'b1100. Then Flagw=2'b01, alu_flags=4'b0011 -> flags_q=4'b1111.
- Condition sweep: preload flags_q to each of 4'b0100 (Z), 4'b0010 (C), 4'b1001 (N,V), 4'b1000 (N); evaluate cond 0..15 against the table -> CondEx matches the table. cond=15 -> 0 for all flag values.
- Gating: flags_q=4'b0000, cond=0 (EQ), RegW=PCS=MemW=1 -> all gated outputs 0. Change cond=1 (NE) -> all 1. NoWrite=1 -> RegWrite=0 while PCSrc=MemWrite=1.
- Squash/bubble: flags_q=4'b0000, cond=0, Flagw=3, alu_flags=4'hF -> flags_q unchanged. cond=14 with instr_valid=0 -> flags_q unchanged. Same stimulus with instr_valid=1 -> flags_q=4'hF next cycle.
- COND_COUNT_EN with CNT_W=4: 17 live executes -> exec_cnt=1 (wrap). 3 squashes -> squash_cnt=3. Reset -> both 0.
